thr_cfg_ctrl: RTL and testbench
===============================

THR_CFG_CTRL -- requirements
Module: thr_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, meaning the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning the number of entries per table bank.
REQ-003 The block SHALL have parameter NBANK, default 4, meaning the number of banks: 0 thr, 1 ch_hash, 2 off_set, 3 ch_gpNo.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: host command present.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: the controller accepts the command this cycle.
REQ-008 The block SHALL have port cmd_op, input, 2 bits: 00 write, 01 read, 10 fill bank, 11 reserved.
REQ-009 The block SHALL have port cmd_addr, input, 16 bits: flat table address, bank = addr/DEPTH.
REQ-010 The block SHALL have port cmd_data, input, BITWIDTH bits: write or fill value.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: read data valid.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: host consumes the response.
REQ-013 The block SHALL have port rsp_data, output, BITWIDTH bits: read data.
REQ-014 The block SHALL have port cmd_err, output, 1 bit: one-cycle pulse when a command is rejected.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have ports mem_addr (16 bits), mem_we (1 bit), mem_re (1 bit) and mem_din (BITWIDTH bits), all outputs, driving the table BRAM port.
REQ-017 The block SHALL have port mem_dout, input, BITWIDTH bits, driven by the table BRAM, which returns data one clock after the mem_re cycle.

Function
REQ-018 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, RD_RSP and FILL.
REQ-019 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-020 Accepted op 11, or any cmd_addr >= NBANK*DEPTH, SHALL pulse cmd_err for the next cycle, cause no mem access, and leave the FSM in IDLE.
REQ-021 Write: acceptance SHALL move to WR; in WR, mem_we=1, mem_addr=cmd_addr and mem_din=cmd_data (both registered at acceptance) for exactly one cycle; then IDLE.
REQ-022 Read: acceptance SHALL move to RD_ISSUE; mem_re=1 and mem_addr=addr for one cycle; then RD_WAIT, in which mem_dout SHALL be captured into rsp_data at the end of the cycle; then RD_RSP.
REQ-023 In RD_RSP, rsp_valid SHALL be 1 and rsp_data SHALL hold stable until rsp_ready=1; on that cycle the FSM SHALL return to IDLE with rsp_valid=0 the following cycle.
REQ-024 Fill: base = (cmd_addr/DEPTH)*DEPTH; FILL SHALL assert mem_we for DEPTH consecutive cycles with mem_addr = base, base+1, ..., base+DEPTH-1 and mem_din = cmd_data, then return to IDLE.
REQ-025 The fill index counter SHALL be log2(DEPTH)+1 bits and SHALL never produce an address outside the selected bank; the wrap from DEPTH-1 SHALL end the fill.
REQ-026 mem_we and mem_re SHALL never be high in the same cycle; outside WR, FILL and RD_ISSUE both SHALL be 0.
REQ-027 cmd_valid SHALL be ignored while busy=1; no command queuing.
REQ-028 Command-to-response latency for a read SHALL be 3 cycles (acceptance edge to the first rsp_valid=1 cycle).

Reset
REQ-029 With rst=1 at a clock edge, the FSM SHALL go to IDLE and cmd_ready SHALL be 1; rsp_valid, cmd_err, busy, mem_we and mem_re SHALL be 0; mem_addr, mem_din and rsp_data SHALL be 0.
REQ-030 rst during FILL or RD_RSP SHALL abort the operation with no further mem writes and SHALL drop the pending response.

Verification
REQ-031 Scenario: write addr 0x0005 data 0x00000120, then read 0x0005 -> exactly one mem_we cycle at 0x0005; rsp_valid 3 cycles after read acceptance; rsp_data=0x00000120.
REQ-032 Scenario: fill with cmd_addr 0x0123 data 0xFFFFFF80 -> 256 consecutive mem_we cycles at addresses 0x0100..0x01FF, busy=1 throughout, cmd_ready=0 throughout.
REQ-033 Scenario: read, then hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable for 10 cycles; IDLE one cycle after rsp_ready=1.
REQ-034 Scenario: cmd_addr 0x0400, and separately op 11 -> a single cmd_err pulse each; no mem_we and no mem_re.
REQ-035 Scenario: rst asserted at fill index 100 -> no mem_we after the reset edge; all outputs at reset values; next write is accepted normally.
REQ-036 Scenario: cmd_valid held high during a fill -> no command is accepted until the fill completes; the held command is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/thr_cfg_ctrl.sv
// Threshold/config table controller: turns host write/read/fill commands into BRAM port cycles.
// Latency: write 1 cycle in WR, read response 3 cycles after acceptance, fill DEPTH cycles.
// Backpressure: accepts one command only when idle; read response is held until rsp_ready.
module thr_cfg_ctrl #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 256,
  parameter int NBANK    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [15:0]         cmd_addr,
  input  logic [BITWIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BITWIDTH-1:0] rsp_data,
  output logic                cmd_err,
  output logic                busy,
  output logic [15:0]         mem_addr,
  output logic                mem_we,
  output logic                mem_re,
  output logic [BITWIDTH-1:0] mem_din,
  input  logic [BITWIDTH-1:0] mem_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(NBANK * DEPTH);
  localparam logic [AW:0] FILL_END = (AW + 1)'(DEPTH - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_RSP, FILL} state_t;

  state_t                state, state_nxt;
  logic [15:0]           addr_q;     // target address, or bank base for a fill
  logic [BITWIDTH-1:0]   data_q;
  logic [AW:0]           fill_idx;   // one spare bit so the last index is representable without wrap ambiguity
  logic                  err_q;
  logic [BITWIDTH-1:0]   rsp_q;
  logic                  accept;
  logic                  cmd_bad;
  logic [15:0]           bank_base;

  assign accept    = cmd_valid && (state == IDLE);
  assign cmd_bad   = (cmd_op == OP_RSVD) || ({16'd0, cmd_addr} >= ADDR_LIMIT);
  assign bank_base = 16'((32'(cmd_addr) / DEPTH) * DEPTH);

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RD_RSP);
  assign rsp_data  = rsp_q;
  assign cmd_err   = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and BRAM port drive; port is quiet outside WR, RD_ISSUE and FILL
  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = 16'd0;
    mem_din   = '0;
    case (state)
      IDLE: begin
        if (accept && !cmd_bad) begin
          case (cmd_op)
            OP_WRITE: state_nxt = WR;
            OP_READ:  state_nxt = RD_ISSUE;
            OP_FILL:  state_nxt = FILL;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      WR: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_din   = data_q;
        state_nxt = IDLE;
      end
      RD_ISSUE: begin
        mem_re    = 1'b1;
        mem_addr  = addr_q;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: state_nxt = RD_RSP;
      RD_RSP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      FILL: begin
        mem_we   = 1'b1;
        mem_addr = addr_q + 16'(fill_idx);
        mem_din  = data_q;
        if (fill_idx == FILL_END) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command capture, fill index, error pulse and read data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= 16'd0;
      data_q   <= '0;
      fill_idx <= '0;
      err_q    <= 1'b0;
      rsp_q    <= '0;
    end else begin
      err_q <= accept && cmd_bad;
      if (accept && !cmd_bad) begin
        data_q   <= cmd_data;
        addr_q   <= (cmd_op == OP_FILL) ? bank_base : cmd_addr;
        fill_idx <= '0;
      end
      if (state == FILL)    fill_idx <= fill_idx + 1'b1;
      if (state == RD_WAIT) rsp_q    <= mem_dout;
    end
  end

endmodule

// File: tb/tb_thr_cfg_ctrl.sv
// Bench for thr_cfg_ctrl: table of single commands plus directed multi-cycle sequences.
// Latency: checks 3-cycle read latency, fill length/addresses, reset abort.
// Backpressure: exercises rsp_ready hold and cmd_valid held during a fill.
module tb_thr_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        cmd_err;
  logic        busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  thr_cfg_ctrl #(.BITWIDTH(32), .DEPTH(256), .NBANK(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cmd_err(cmd_err), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Table BRAM model: one-cycle read latency
  logic [31:0] tbmem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) tbmem[i] = 32'd0;
    mem_dout = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_we && mem_addr < 16'd1024) tbmem[mem_addr[9:0]] <= mem_din;
    if (mem_re) mem_dout <= tbmem[mem_addr[9:0]];
  end

  // Port monitor, sampled on the falling edge
  int          cyc = 0;
  logic [15:0] we_q[$];
  logic [31:0] din_q[$];
  int          cyc_q[$];
  int          re_cnt = 0;
  int          overlap = 0;
  int          bad_busy = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_we) begin
      we_q.push_back(mem_addr);
      din_q.push_back(mem_din);
      cyc_q.push_back(cyc);
      if (!busy || cmd_ready) bad_busy++;
    end
    if (mem_re) re_cnt++;
    if (mem_we && mem_re) overlap++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    we_q.delete();
    din_q.delete();
    cyc_q.delete();
    re_cnt = 0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_flags"}, 64'({cmd_ready, rsp_valid, cmd_err, busy, mem_we, mem_re}), 64'b100000);
    chk({nm, "_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_din_rsp"}, {mem_din, rsp_data}, 64'd0);
  endtask

  // Present a command and return on the cycle after it is accepted
  task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data);
    int n;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 600) begin tick(); n++; end
    if (n >= 600) chk("send_timeout", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 600) begin tick(); n++; end
    if (n >= 600) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    logic        exp_err;
    int          exp_we;
    int          exp_re;
    logic [31:0] exp_rsp;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat;
    int bad;
    int sz;

    vecs[0]  = '{2'b00, 16'h0005, 32'h00000120, 1'b0, 1,   0, 32'h0, 16'h0005};
    vecs[1]  = '{2'b01, 16'h0005, 32'h0,        1'b0, 0,   1, 32'h00000120, 16'h0};
    vecs[2]  = '{2'b00, 16'h03FF, 32'hDEADBEEF, 1'b0, 1,   0, 32'h0, 16'h03FF};
    vecs[3]  = '{2'b01, 16'h03FF, 32'h0,        1'b0, 0,   1, 32'hDEADBEEF, 16'h0};
    vecs[4]  = '{2'b01, 16'h0006, 32'h0,        1'b0, 0,   1, 32'h0, 16'h0};
    vecs[5]  = '{2'b00, 16'h0400, 32'h11111111, 1'b1, 0,   0, 32'h0, 16'h0};
    vecs[6]  = '{2'b11, 16'h0010, 32'h22222222, 1'b1, 0,   0, 32'h0, 16'h0};
    vecs[7]  = '{2'b00, 16'hFFFF, 32'h33333333, 1'b1, 0,   0, 32'h0, 16'h0};
    vecs[8]  = '{2'b01, 16'h0400, 32'h0,        1'b1, 0,   0, 32'h0, 16'h0};
    vecs[9]  = '{2'b10, 16'h0280, 32'h00000055, 1'b0, 256, 0, 32'h0, 16'h02FF};
    vecs[10] = '{2'b01, 16'h02A7, 32'h0,        1'b0, 0,   1, 32'h00000055, 16'h0};
    vecs[11] = '{2'b01, 16'h03FF, 32'h0,        1'b0, 0,   1, 32'hDEADBEEF, 16'h0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 16'd0; cmd_data = 32'd0;
    rsp_ready = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single-command table
    for (int i = 0; i < 12; i++) begin
      clear_mon();
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      if (vecs[i].exp_err) begin
        chk($sformatf("v%0d_err", i), 64'(cmd_err), 64'd1);
        chk($sformatf("v%0d_ready", i), 64'(cmd_ready), 64'd1);
        tick();
        chk($sformatf("v%0d_err_pulse", i), 64'(cmd_err), 64'd0);
      end else if (vecs[i].op == 2'b01) begin
        wait_rsp(lat);
        chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
        chk($sformatf("v%0d_rsp", i), 64'(rsp_data), 64'(vecs[i].exp_rsp));
      end
      wait_idle();
      tick();
      chk($sformatf("v%0d_we_cnt", i), 64'(we_q.size()), 64'(vecs[i].exp_we));
      chk($sformatf("v%0d_re_cnt", i), 64'(re_cnt), 64'(vecs[i].exp_re));
      if (vecs[i].exp_we > 0 && we_q.size() > 0) begin
        chk($sformatf("v%0d_last_addr", i), 64'(we_q[$]), 64'(vecs[i].exp_last));
        chk($sformatf("v%0d_last_din", i), 64'(din_q[$]), 64'(vecs[i].data));
      end
    end

    // Fill bank 1 with a write held on cmd_valid for the whole fill
    clear_mon();
    bad_busy = 0;
    cmd_op = 2'b10; cmd_addr = 16'h0123; cmd_data = 32'hFFFFFF80; cmd_valid = 1'b1;
    tick();
    cmd_op = 2'b00; cmd_addr = 16'h0050; cmd_data = 32'h000000AB;
    sz = 0;
    while (we_q.size() < 257 && sz < 600) begin tick(); sz++; end
    cmd_valid = 1'b0;
    wait_idle();
    tick();
    chk("fill_we_cnt", 64'(we_q.size()), 64'd257);
    bad = 0;
    for (int i = 0; i < 256 && i < we_q.size(); i++)
      if (we_q[i] != 16'(16'h0100 + i) || din_q[i] != 32'hFFFFFF80) bad++;
    chk("fill_seq", 64'(bad), 64'd0);
    chk("fill_busy_ready", 64'(bad_busy), 64'd0);
    if (we_q.size() >= 257) begin
      chk("held_cmd_addr", 64'(we_q[256]), 64'h0050);
      chk("held_cmd_gap", 64'(cyc_q[256] - cyc_q[255]), 64'd2);
    end

    // Response held under rsp_ready=0
    rsp_ready = 1'b0;
    send(2'b01, 16'h0050, 32'd0);
    wait_rsp(lat);
    chk("hold_latency", 64'(lat), 64'd3);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_data === 32'h000000AB)) bad++;
      tick();
    end
    chk("hold_stable", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    tick();
    chk("hold_release", 64'({busy, rsp_valid, cmd_ready}), 64'b001);

    // Reset at fill index 100
    clear_mon();
    send(2'b10, 16'h0200, 32'h00000077);
    sz = 0;
    while (!(we_q.size() > 0 && we_q[$] == 16'h0264) && sz < 600) begin tick(); sz++; end
    rst = 1'b1;
    sz = we_q.size();
    tick();
    chk_reset_vals("fill_abort");
    tick();
    rst = 1'b0;
    tick();
    chk("abort_we_cnt", 64'(we_q.size()), 64'd101);
    chk("abort_mem_next", 64'(tbmem[16'h0265]), 64'h55);
    chk("abort_mem_last", 64'(tbmem[16'h0264]), 64'h77);
    send(2'b00, 16'h0201, 32'h00000099);
    wait_idle();
    tick();
    chk("post_abort_we_cnt", 64'(we_q.size()), 64'(sz + 1));
    if (we_q.size() > 0) chk("post_abort_addr", 64'(we_q[$]), 64'h0201);

    // Reset while a response is pending
    rsp_ready = 1'b0;
    send(2'b01, 16'h0005, 32'd0);
    wait_rsp(lat);
    chk("rsp_abort_pending", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rsp_abort");
    tick();
    chk("rsp_abort_stays", 64'({rsp_valid, busy}), 64'd0);
    rsp_ready = 1'b1;

    chk("no_we_re_overlap", 64'(overlap), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
